// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, FSM state codes and per-beat legality helpers for the SRAM responder.
package axi4_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [2:0] Size4B = 3'b010;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StArAcc = 3'd1;
  localparam logic [2:0] StRdata = 3'd2;
  localparam logic [2:0] StAwAcc = 3'd3;
  localparam logic [2:0] StWdata = 3'd4;
  localparam logic [2:0] StBresp = 3'd5;

  // Unsigned offset compare: addresses below the base wrap to huge indices and fail too.
  function automatic logic beat_err(input logic [31:0] addr, input logic [2:0] size,
                                    input logic [1:0] burst, input logic [31:0] base,
                                    input int unsigned depth);
    logic [31:0] idx;
    idx = (addr - base) >> 2;
    return (idx >= depth) || (size != Size4B) ||
           !((burst == BurstFixed) || (burst == BurstIncr));
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BurstIncr) ? addr + 32'd4 : addr;
  endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port word SRAM with byte enables and a registered read port that can be forced to zero.
module sram_1rw_be #(
  parameter int unsigned DEPTH = 4096,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic          i_rd_clr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Read register holds between reads so the bus data stays stable during stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_en && !i_we) begin
      r_q <= i_rd_clr ? 32'd0 : r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/axi4_sram_responder.sv
// AXI4 slave serving one transaction at a time from on-chip SRAM; FIXED/INCR 32-bit bursts,
// SLVERR on out-of-range, wrong size, unsupported burst or wlast mismatch.
module axi4_sram_responder
  import axi4_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_slave_awvalid,
  output logic        io_slave_awready,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  input  logic        io_slave_wvalid,
  output logic        io_slave_wready,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  output logic        io_slave_bvalid,
  input  logic        io_slave_bready,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  input  logic        io_slave_arvalid,
  output logic        io_slave_arready,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  output logic        io_slave_rvalid,
  input  logic        io_slave_rready,
  output logic [31:0] io_slave_rdata,
  output logic [1:0]  io_slave_rresp,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  logic [2:0]  r_state;
  logic        r_prio_wr;
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic        r_werr;
  logic        r_arready;
  logic        r_awready;
  logic        r_wready;
  logic        r_rvalid;
  logic [1:0]  r_rresp;
  logic        r_rlast;
  logic [3:0]  r_rid;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [3:0]  r_bid;

  logic          w_grant_rd;
  logic          w_grant_wr;
  logic          w_rd_hs;
  logic          w_wr_hs;
  logic          w_last;
  logic [31:0]   w_addr_nxt;
  logic          w_ar_err;
  logic          w_nxt_err;
  logic          w_cur_err;
  logic          w_beat_bad;
  logic          w_mem_en;
  logic          w_mem_we;
  logic          w_mem_clr;
  logic [AW-1:0] w_mem_addr;
  logic [31:0]   w_mem_rdata;

  // On a simultaneous request the channel not granted last time wins.
  assign w_grant_rd = io_slave_arvalid && (!io_slave_awvalid || !r_prio_wr);
  assign w_grant_wr = io_slave_awvalid && !w_grant_rd;

  assign w_rd_hs    = r_rvalid && io_slave_rready;
  assign w_wr_hs    = r_wready && io_slave_wvalid;
  assign w_last     = (r_cnt == r_len);
  assign w_addr_nxt = next_addr(r_addr, r_burst);
  assign w_ar_err   = beat_err(io_slave_araddr, io_slave_arsize, io_slave_arburst,
                               BASE_ADDR, DEPTH_WORDS);
  assign w_nxt_err  = beat_err(w_addr_nxt, r_size, r_burst, BASE_ADDR, DEPTH_WORDS);
  assign w_cur_err  = beat_err(r_addr, r_size, r_burst, BASE_ADDR, DEPTH_WORDS);
  assign w_beat_bad = w_cur_err || (io_slave_wlast != w_last);

  // Next read beat is fetched on the handshake edge so rvalid can stay high back-to-back.
  always_comb begin
    w_mem_en   = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_clr  = 1'b0;
    w_mem_addr = '0;
    case (r_state)
      StArAcc: begin
        w_mem_en   = 1'b1;
        w_mem_addr = word_idx(io_slave_araddr);
        w_mem_clr  = w_ar_err;
      end
      StRdata: begin
        if (w_rd_hs && !w_last) begin
          w_mem_en   = 1'b1;
          w_mem_addr = word_idx(w_addr_nxt);
          w_mem_clr  = w_nxt_err;
        end
      end
      StWdata: begin
        if (w_wr_hs && !w_cur_err) begin
          w_mem_en   = 1'b1;
          w_mem_we   = 1'b1;
          w_mem_addr = word_idx(r_addr);
        end
      end
      default: ;
    endcase
  end

  sram_1rw_be #(
    .DEPTH(DEPTH_WORDS)
  ) u_sram (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_en    (w_mem_en),
    .i_we    (w_mem_we),
    .i_be    (io_slave_wstrb),
    .i_addr  (w_mem_addr),
    .i_wdata (io_slave_wdata),
    .i_rd_clr(w_mem_clr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_prio_wr <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_werr    <= 1'b0;
      r_arready <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RespOkay;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RespOkay;
      r_bid     <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_grant_rd) begin
            r_state   <= StArAcc;
            r_arready <= 1'b1;
            r_prio_wr <= 1'b1;
          end else if (w_grant_wr) begin
            r_state   <= StAwAcc;
            r_awready <= 1'b1;
            r_prio_wr <= 1'b0;
          end
        end
        StArAcc: begin
          r_arready <= 1'b0;
          r_addr    <= io_slave_araddr;
          r_len     <= io_slave_arlen;
          r_size    <= io_slave_arsize;
          r_burst   <= io_slave_arburst;
          r_cnt     <= '0;
          r_rid     <= io_slave_arid;
          r_rvalid  <= 1'b1;
          r_rresp   <= w_ar_err ? RespSlverr : RespOkay;
          r_rlast   <= (io_slave_arlen == 8'd0);
          r_state   <= StRdata;
        end
        StRdata: begin
          if (w_rd_hs) begin
            if (w_last) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= StIdle;
            end else begin
              r_addr  <= w_addr_nxt;
              r_cnt   <= r_cnt + 8'd1;
              r_rresp <= w_nxt_err ? RespSlverr : RespOkay;
              r_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        StAwAcc: begin
          r_awready <= 1'b0;
          r_addr    <= io_slave_awaddr;
          r_len     <= io_slave_awlen;
          r_size    <= io_slave_awsize;
          r_burst   <= io_slave_awburst;
          r_cnt     <= '0;
          r_bid     <= io_slave_awid;
          r_werr    <= 1'b0;
          r_wready  <= 1'b1;
          r_state   <= StWdata;
        end
        StWdata: begin
          if (w_wr_hs) begin
            if (w_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_werr || w_beat_bad) ? RespSlverr : RespOkay;
              r_state  <= StBresp;
            end else begin
              r_werr <= r_werr || w_beat_bad;
              r_addr <= w_addr_nxt;
              r_cnt  <= r_cnt + 8'd1;
            end
          end
        end
        StBresp: begin
          if (io_slave_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_slave_arready = r_arready;
  assign io_slave_awready = r_awready;
  assign io_slave_wready  = r_wready;
  assign io_slave_rvalid  = r_rvalid;
  assign io_slave_rdata   = w_mem_rdata;
  assign io_slave_rresp   = r_rresp;
  assign io_slave_rlast   = r_rlast;
  assign io_slave_rid     = r_rid;
  assign io_slave_bvalid  = r_bvalid;
  assign io_slave_bresp   = r_bresp;
  assign io_slave_bid     = r_bid;

endmodule

// File: tb/tb_axi4_sram_responder.sv
// Scoreboard bench: tasks push expected beats from a word-array model, monitors pop and compare.
module tb_axi4_sram_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awid, wstrb, bid, arid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, bresp, arburst, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;

  always #5 clock = ~clock;

  axi4_sram_responder #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .io_slave_awvalid(awvalid),
    .io_slave_awready(awready),
    .io_slave_awaddr (awaddr),
    .io_slave_awid   (awid),
    .io_slave_awlen  (awlen),
    .io_slave_awsize (awsize),
    .io_slave_awburst(awburst),
    .io_slave_wvalid (wvalid),
    .io_slave_wready (wready),
    .io_slave_wdata  (wdata),
    .io_slave_wstrb  (wstrb),
    .io_slave_wlast  (wlast),
    .io_slave_bvalid (bvalid),
    .io_slave_bready (bready),
    .io_slave_bresp  (bresp),
    .io_slave_bid    (bid),
    .io_slave_arvalid(arvalid),
    .io_slave_arready(arready),
    .io_slave_araddr (araddr),
    .io_slave_arid   (arid),
    .io_slave_arlen  (arlen),
    .io_slave_arsize (arsize),
    .io_slave_arburst(arburst),
    .io_slave_rvalid (rvalid),
    .io_slave_rready (rready),
    .io_slave_rdata  (rdata),
    .io_slave_rresp  (rresp),
    .io_slave_rlast  (rlast),
    .io_slave_rid    (rid)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rexp_t       r_q[$];
  bexp_t       b_q[$];
  byte         grant_q[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  int          n_vec = 0;
  int          n_err = 0;
  int          rr_mode = 0;
  int          br_mode = 0;
  logic        hold_v = 1'b0;
  logic [38:0] hold_d;
  rexp_t       mon_r;
  bexp_t       mon_b;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic bad(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bu);
    return !(a >= BASE && a < BASE + 32'(4 * DEPTH)) || sz != 3'b010 ||
           (bu != 2'b00 && bu != 2'b01);
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] bu, input int i);
    return (bu == 2'b01) ? a + 32'(4 * i) : a;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic wl_of(input int i, input int len, input int mode);
    case (mode)
      1:       return i == 0;
      2:       return 1'b0;
      default: return i == len;
    endcase
  endfunction

  function automatic logic [49:0] all_outs();
    return {arready, awready, wready, rvalid, rdata, rresp, rlast, rid, bvalid, bresp, bid};
  endfunction

  task automatic push_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input logic [2:0] sz, input logic [1:0] bu);
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a;
      rexp_t e;
      a = beat_addr(addr, bu, i);
      e.resp = bad(a, sz, bu) ? 2'b10 : 2'b00;
      e.data = bad(a, sz, bu) ? 32'd0 : mem_m[widx(a)];
      e.last = (i == len);
      e.id   = id;
      r_q.push_back(e);
    end
  endtask

  task automatic drain_r();
    int t = 0;
    while (r_q.size() != 0 && t < 1000) begin @(negedge clock); t++; end
    check("r_drain", 64'(r_q.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic drain_b();
    int t = 0;
    while (b_q.size() != 0 && t < 1000) begin @(negedge clock); t++; end
    check("b_drain", 64'(b_q.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic ar_handshake(input logic [31:0] addr, input logic [3:0] id, input int len,
                              input logic [2:0] sz, input logic [1:0] bu);
    int t = 0;
    arvalid = 1'b1; araddr = addr; arid = id; arlen = 8'(len); arsize = sz; arburst = bu;
    do begin @(negedge clock); t++; end while (!arready && t < 200);
    check("ar_handshake", 64'(arready), 64'd1);
    @(posedge clock); #1;
    arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                         input logic [2:0] sz, input logic [1:0] bu);
    push_read(addr, id, len, sz, bu);
    ar_handshake(addr, id, len, sz, bu);
    drain_r();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                          input logic [2:0] sz, input logic [1:0] bu, input int wl_mode);
    logic any = 1'b0;
    int   t = 0;
    bexp_t e;
    for (int i = 0; i <= len; i++) begin
      logic [31:0] a;
      a = beat_addr(addr, bu, i);
      if (!bad(a, sz, bu)) begin
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mem_m[widx(a)][8*b +: 8] = wd[i][8*b +: 8];
      end
      if (bad(a, sz, bu) || wl_of(i, len, wl_mode) != (i == len)) any = 1'b1;
    end
    e.resp = any ? 2'b10 : 2'b00;
    e.id   = id;
    b_q.push_back(e);
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = 8'(len); awsize = sz; awburst = bu;
    do begin @(negedge clock); t++; end while (!awready && t < 200);
    check("aw_handshake", 64'(awready), 64'd1);
    @(posedge clock); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(posedge clock); #1; end
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = wl_of(i, len, wl_mode);
      t = 0;
      do begin @(negedge clock); t++; end while (!wready && t < 200);
      check("w_handshake", 64'(wready), 64'd1);
      @(posedge clock); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    drain_b();
  endtask

  task automatic fill_wd(input int n, input logic [3:0] strb);
    for (int i = 0; i < n; i++) begin wd[i] = $urandom; ws[i] = strb; end
  endtask

  initial forever begin
    @(posedge clock); #1;
    case (rr_mode)
      0:       rready = 1'b1;
      1:       rready = ~rready;
      default: rready = 1'($urandom_range(0, 1));
    endcase
    bready = (br_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  always @(negedge clock) begin
    if (reset) begin
      if (arready) grant_q.push_back("R");
      if (awready) grant_q.push_back("W");
      if (hold_v && rvalid) check("r_stable", 64'({rdata, rresp, rlast, rid}), 64'(hold_d));
      hold_v = rvalid && !rready;
      hold_d = {rdata, rresp, rlast, rid};
      if (rvalid && rready) begin
        if (r_q.size() == 0) begin
          check("r_unexpected", 64'(rvalid), 64'd0);
        end else begin
          mon_r = r_q.pop_front();
          check("rdata", 64'(rdata), 64'(mon_r.data));
          check("rresp", 64'(rresp), 64'(mon_r.resp));
          check("rlast", 64'(rlast), 64'(mon_r.last));
          check("rid", 64'(rid), 64'(mon_r.id));
        end
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) begin
          check("b_unexpected", 64'(bvalid), 64'd0);
        end else begin
          mon_b = b_q.pop_front();
          check("bresp", 64'(bresp), 64'(mon_b.resp));
          check("bid", 64'(bid), 64'(mon_b.id));
        end
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int t;
    reset = 1'b0; rready = 1'b1; bready = 1'b1;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
    // Out-of-range read held through reset: SLVERR with rdata 0 once served.
    arvalid = 1'b1; araddr = 32'h7FFF_FFFC; arid = 4'h3; arlen = 0; arsize = 3'b010;
    arburst = 2'b01;
    push_read(32'h7FFF_FFFC, 4'h3, 0, 3'b010, 2'b01);
    repeat (3) @(posedge clock);
    #1 check("reset_outputs", 64'(all_outs()), 64'd0);
    reset = 1'b1;
    @(negedge clock); check("arready_cycle1", 64'(arready), 64'd0);
    @(negedge clock); check("arready_cycle2", 64'(arready), 64'd1);
    @(posedge clock); #1 arvalid = 1'b0;
    drain_r();

    fill_wd(64, 4'hF);
    do_write(BASE, 4'h0, 63, 3'b010, 2'b01, 0);

    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(32'h8000_0010, 4'h5, 0, 3'b010, 2'b01, 0);
    do_read(32'h8000_0010, 4'h9, 0, 3'b010, 2'b01);

    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    do_write(BASE, 4'h1, 3, 3'b010, 2'b01, 0);
    rr_mode = 1;
    do_read(BASE, 4'h2, 3, 3'b010, 2'b01);
    rr_mode = 0;

    wd[0] = 32'h0; ws[0] = 4'hF;
    do_write(BASE, 4'h4, 0, 3'b010, 2'b01, 0);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    do_write(BASE, 4'h4, 0, 3'b010, 2'b01, 0);
    do_read(BASE, 4'h6, 0, 3'b010, 2'b01);
    wd[0] = 32'h1234_5678; wd[1] = 32'hCAFE_F00D; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(BASE, 4'h7, 1, 3'b010, 2'b00, 0);
    do_read(BASE, 4'h8, 0, 3'b010, 2'b01);

    do_read(32'h7FFF_FFFC, 4'hA, 0, 3'b010, 2'b01);
    fill_wd(2, 4'hF);
    do_write(BASE + 32'h20, 4'hB, 1, 3'b010, 2'b01, 1);
    do_write(BASE + 32'h20, 4'hB, 1, 3'b010, 2'b01, 2);
    do_read(BASE + 32'h20, 4'hC, 0, 3'b001, 2'b01);
    do_read(BASE + 32'h20, 4'hD, 1, 3'b010, 2'b10);
    do_read(BASE + 32'hF8, 4'hE, 3, 3'b010, 2'b01);
    fill_wd(1, 4'hF);
    do_write(BASE + 32'h100, 4'hF, 0, 3'b010, 2'b01, 0);

    // Last grant is a write, so both simultaneous pairs should go read then write.
    fill_wd(2, 4'hF);
    do_write(BASE + 32'h40, 4'h1, 0, 3'b010, 2'b01, 0);
    grant_q.delete();
    fork
      do_read(BASE + 32'h80, 4'h2, 1, 3'b010, 2'b01);
      do_write(BASE + 32'hC0, 4'h3, 1, 3'b010, 2'b01, 0);
    join
    fork
      do_write(BASE + 32'h44, 4'h4, 0, 3'b010, 2'b01, 0);
      do_read(BASE + 32'h84, 4'h5, 1, 3'b010, 2'b01);
    join
    check("grant_count", 64'(grant_q.size()), 64'd4);
    if (grant_q.size() == 4)
      check("grant_order", 64'({grant_q[0], grant_q[1], grant_q[2], grant_q[3]}),
            64'(32'h5257_5257));

    rr_mode = 1;
    push_read(BASE, 4'h6, 3, 3'b010, 2'b01);
    ar_handshake(BASE, 4'h6, 3, 3'b010, 2'b01);
    t = 0;
    while (r_q.size() > 3 && t < 200) begin @(negedge clock); t++; end
    check("abort_first_beat", 64'(r_q.size()), 64'd3);
    #2 reset = 1'b0;
    #1 check("abort_outputs", 64'(all_outs()), 64'd0);
    r_q.delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    rr_mode = 0;
    do_read(BASE + 32'h8, 4'h7, 1, 3'b010, 2'b01);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      logic [1:0]  bu;
      int          len;
      a   = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      len = $urandom_range(0, 7);
      bu  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      sz  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b010;
      rr_mode = $urandom_range(0, 2);
      br_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        do_write(a, 4'($urandom), len, sz, bu, ($urandom_range(0, 7) == 0) ? 2 : 0);
      end else begin
        do_read(a, 4'($urandom), len, sz, bu);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
